// File: rtl/replica_pkg.sv
// Shared constants and types for the replica distance table and its host-side loader.
package replica_pkg;

  localparam int unsigned city_num     = 4;
  localparam int unsigned city_num_log = 2;

  typedef logic [15:0]               distance_data_t;
  typedef logic [city_num_log-1:0]   city_idx_t;
  typedef logic [2*city_num_log-1:0] dist_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    DIAG,
    LOAD,
    MIRROR,
    DONE
  } loader_state_t;

endpackage

// File: rtl/distance_loader_if.sv
// Upper-triangle distance stream plus the replica table write port.
interface distance_loader_if;
  import replica_pkg::*;

  logic           s_valid;
  logic           s_ready;
  distance_data_t s_data;

  logic           distance_write;
  dist_addr_t     distance_w_addr;
  distance_data_t distance_w_data;

  // master: the loader (consumes the stream, drives the write port)
  modport master (
    input  s_valid,
    input  s_data,
    output s_ready,
    output distance_write,
    output distance_w_addr,
    output distance_w_data
  );

  // slave: host stream source and replica table sink
  modport slave (
    output s_valid,
    output s_data,
    input  s_ready,
    input  distance_write,
    input  distance_w_addr,
    input  distance_w_data
  );

endinterface

// File: rtl/distance_loader.sv
// Writes the zero diagonal, then each streamed upper-triangle entry and its transpose,
// into every replica's distance table; pulses done with the final mirrored write.
module distance_loader
  import replica_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  distance_loader_if.master bus,
  output logic              busy,
  output logic              done
);

  localparam city_idx_t LastIdx = city_idx_t'(city_num - 1);
  localparam city_idx_t PenIdx  = city_idx_t'(city_num - 2);

  loader_state_t  state_q, state_d;
  city_idx_t      k_q, k_d;
  city_idx_t      i_q, i_d;
  city_idx_t      j_q, j_d;
  distance_data_t hold_q, hold_d;
  logic           write_q, write_d;
  dist_addr_t     addr_q, addr_d;
  distance_data_t wdata_q, wdata_d;
  logic           done_q, done_d;

  logic handshake;
  logic last_pair;

  assign handshake = (state_q == LOAD) && bus.s_valid;
  assign last_pair = (i_q == PenIdx) && (j_q == LastIdx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = DIAG;
      DIAG:       if (k_q == LastIdx) state_d = LOAD;
      LOAD:       if (handshake) state_d = MIRROR;
      MIRROR:     state_d = last_pair ? DONE : LOAD;
      default:    state_d = IDLE;
    endcase
  end

  // Counters, latched word and next values of the registered write port.
  always_comb begin
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    hold_d  = hold_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          k_d = '0;
          i_d = '0;
          j_d = city_idx_t'(1);
        end
      end
      DIAG: begin
        write_d = 1'b1;
        addr_d  = {k_q, k_q};
        wdata_d = '0;
        if (k_q == LastIdx) begin
          k_d = '0;
          i_d = '0;
          j_d = city_idx_t'(1);
        end else begin
          k_d = k_q + city_idx_t'(1);
        end
      end
      LOAD: begin
        if (handshake) begin
          hold_d  = bus.s_data;
          write_d = 1'b1;
          addr_d  = {i_q, j_q};
          wdata_d = bus.s_data;
        end
      end
      MIRROR: begin
        write_d = 1'b1;
        addr_d  = {j_q, i_q};
        wdata_d = hold_q;
        if (last_pair) begin
          done_d = 1'b1;
        end else if (j_q == LastIdx) begin
          // Triangular wrap: next row starts just right of its diagonal.
          i_d = i_q + city_idx_t'(1);
          j_d = i_q + city_idx_t'(2);
        end else begin
          j_d = j_q + city_idx_t'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= city_idx_t'(1);
      hold_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      hold_q  <= hold_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.s_ready         = (state_q == LOAD);
  assign bus.distance_write  = write_q;
  assign bus.distance_w_addr = addr_q;
  assign bus.distance_w_data = wdata_q;
  assign done                = done_q;
  // Writes trail the state by one cycle, so busy covers the registered done cycle too.
  assign busy = (state_q == DIAG) || (state_q == LOAD) || (state_q == MIRROR) || done_q;

endmodule

// File: tb/tb_distance_loader.sv
// Directed scoreboard bench for distance_loader: expected writes are queued as stimulus is
// driven and popped as the write port fires.
module tb_distance_loader;
  import replica_pkg::*;

  typedef struct {
    dist_addr_t     addr;
    distance_data_t data;
    logic           last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  distance_loader_if bus();

  distance_loader dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   wr_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int r, input int c, input distance_data_t d, input logic last);
    exp_t e;
    e.addr = {city_idx_t'(r), city_idx_t'(c)};
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // One clock; sample on the falling edge and score any write.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (bus.distance_write === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.distance_write), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("w_addr", 64'(bus.distance_w_addr), 64'(e.addr));
        check("w_data", 64'(bus.distance_w_data), 64'(e.data));
        check("done_with_write", 64'(done), 64'(e.last));
      end
    end else begin
      check("done_no_write", 64'(done), 64'd0);
    end
  endtask

  task automatic do_start();
    for (int k = 0; k < city_num; k++) push_exp(k, k, '0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ready(input bit poke);
    for (int n = 0; n < 40; n++) begin
      if (bus.s_ready === 1'b1) break;
      if (poke && n == 0) start = 1'b1;
      step();
      start = 1'b0;
    end
    check("ready_timeout", 64'(bus.s_ready), 64'd1);
  endtask

  // Full table load: gap = idle s_valid cycles before each word; poke pulses start while busy.
  task automatic run_load(input int gap, input bit max_data, input bit poke);
    distance_data_t w;
    int n = 0;
    int w0;
    int base = wr_cnt;
    if (gap > 0) bus.s_valid = 1'b0;
    do_start();
    for (int i = 0; i < city_num - 1; i++) begin
      for (int j = i + 1; j < city_num; j++) begin
        w = max_data ? '1 : distance_data_t'(10 * (n + 1));
        n++;
        wait_ready(poke && n == 1);
        for (int g = 0; g < gap; g++) begin
          bus.s_valid = 1'b0;
          check("ready_held_in_load", 64'(bus.s_ready), 64'd1);
          w0 = wr_cnt;
          step();
          check("no_write_in_gap", 64'(wr_cnt), 64'(w0));
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        push_exp(i, j, w, 1'b0);
        push_exp(j, i, w, (i == city_num - 2) && (j == city_num - 1));
        step();
        if (gap > 0) bus.s_valid = 1'b0;
        bus.s_data = ~w;
        check("ready_low_in_mirror", 64'(bus.s_ready), 64'd0);
        if (poke && n == 2) start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    check("busy_at_done", 64'(busy), 64'd1);
    step();
    check("busy_after_done", 64'(busy), 64'd0);
    check("ready_after_done", 64'(bus.s_ready), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("write_count", 64'(wr_cnt - base), 64'(city_num * city_num));
  endtask

  task automatic idle_valid(input string tag);
    int w0 = wr_cnt;
    bus.s_valid = 1'b1;
    bus.s_data  = distance_data_t'(99);
    for (int n = 0; n < 4; n++) begin
      check(tag, 64'(bus.s_ready), 64'd0);
      step();
    end
    check("no_write_idle", 64'(wr_cnt), 64'(w0));
    check("not_busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    #12;
    check("rst_write", 64'(bus.distance_write), 64'd0);
    check("rst_addr", 64'(bus.distance_w_addr), 64'd0);
    check("rst_data", 64'(bus.distance_w_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    idle_valid("ready_in_idle");
    run_load(0, 1'b0, 1'b0);
    idle_valid("ready_in_done");
    run_load(3, 1'b0, 1'b0);
    run_load(0, 1'b0, 1'b1);
    run_load(0, 1'b1, 1'b0);

    // Abort after the {0,2} write, then reload from scratch.
    bus.s_valid = 1'b1;
    do_start();
    wait_ready(1'b0);
    bus.s_data = distance_data_t'(10);
    push_exp(0, 1, distance_data_t'(10), 1'b0);
    push_exp(1, 0, distance_data_t'(10), 1'b0);
    step();
    step();
    wait_ready(1'b0);
    bus.s_data = distance_data_t'(20);
    push_exp(0, 2, distance_data_t'(20), 1'b0);
    push_exp(2, 0, distance_data_t'(20), 1'b0);
    step();
    check("pre_abort_write", 64'(bus.distance_write), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_write", 64'(bus.distance_write), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(bus.s_ready), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    run_load(0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/distance_loader.md
Name: distance_loader

Overview:
- Host-side writer for the per-replica distance table. Consumes a valid/ready stream carrying only the upper triangle of the symmetric city-distance matrix.
- Drives the distance_write / distance_w_addr / distance_w_data write port of every replica.
- Generates all writes: zero diagonal, each streamed entry, and its mirrored (transposed) entry, then reports completion.

Parameters:
- city_num, package constant (replica_pkg), number of cities; 2 <= city_num <= 2**city_num_log.
- city_num_log, package constant, index width in bits.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle pulse; begins a table load. Honoured only in IDLE or DONE.
- s_valid  input  1  stream word valid.
- s_ready  output  1  stream word accepted when s_valid && s_ready at a rising edge.
- s_data  input  distance_data_t  distance for the current (i,j) pair, i<j.
- distance_write  output  1  write strobe to the replicas.
- distance_w_addr  output  city_num_log*2  {row, col}; row in the upper city_num_log bits.
- distance_w_data  output  distance_data_t  write data.
- busy  output  1  high in DIAG, LOAD and MIRROR.
- done  output  1  one-cycle pulse when the last mirrored write is issued.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters i=0, j=1, k=0.
- All write-port outputs are registered.
- distance_write is high for exactly one cycle per write. When it is low, addr and data hold their last values.
- FSM states and transitions:
  - IDLE: on start -> DIAG; k=0.
  - DIAG: one write per cycle, addr {k,k}, data 0. k increments; after k=city_num-1 -> LOAD with i=0, j=1. s_ready=0.
  - LOAD: s_ready=1. On handshake, latch s_data; next cycle write {i,j} with s_data; -> MIRROR. With no handshake, stay in LOAD with no write.
  - MIRROR: s_ready=0. Write {j,i} with the latched data.
    - If i==city_num-2 and j==city_num-1 (last pair): assert done in the same cycle; -> DONE.
    - Otherwise advance: if j==city_num-1 then i=i+1, j=i+2; else j=j+1. -> LOAD.
  - DONE: busy=0, s_ready=0. On start -> DIAG, restarting the whole sequence.
- Throughput: at most one stream word per 2 cycles.
- Write counts: city_num diagonal writes, then city_num*(city_num-1) off-diagonal writes.
- s_ready is combinational from state only (high iff state==LOAD). It never depends on s_valid.
- start asserted while busy is ignored and has no effect on counters.
- s_valid outside LOAD is ignored; no word is consumed.
- s_data need not be held after the handshake.
- Reset asserted mid-operation: immediately returns to IDLE; the write strobe drops asynchronously. The partially written table is not cleaned up; the host reissues start.
- city_num=2: DIAG writes 2 entries, then LOAD/MIRROR run once, then DONE.

Decomposition:
- replica_pkg (shared): city_num, city_num_log, distance_data_t, and a new loader_state_t enum {IDLE, DIAG, LOAD, MIRROR, DONE}.
- No sub-module. The pair counter (i,j with triangular wrap) is inline. One flat module of roughly 150 lines.

Test Plan:
- city_num=4, s_valid held high, words 10,20,30,40,50,60:
  - Writes {0,0}..{3,3} with data 0.
  - Then {0,1}=10, {1,0}=10, {0,2}=20, {2,0}=20, {0,3}=30, {3,0}=30, {1,2}=40, {2,1}=40, {1,3}=50, {3,1}=50, {2,3}=60, {3,2}=60.
  - 16 writes total; done pulses with the {3,2} write; busy falls the next cycle.
- Same load with s_valid low for 3 cycles before each word:
  - Identical write sequence and data.
  - No writes and no index advance while s_valid is low.
  - s_ready stays high throughout LOAD.
- start pulsed during DIAG and again during MIRROR:
  - Sequence unchanged, still exactly 16 writes.
  - A second start in DONE restarts at {0,0}.
- reset driven low after the {0,2} write:
  - distance_write=0, busy=0, s_ready=0 immediately.
  - After release and start, the sequence restarts at {0,0}.
- s_data at the all-ones maximum of distance_data_t for every pair: both {i,j} and {j,i} carry the all-ones value unmodified.
- s_valid asserted in IDLE and in DONE with no start: s_ready=0, no writes, no word consumed.
